// File: rtl/pipe_pkg.sv
// pipe_pkg: shared occupancy-state encoding and default payload widths for pipeline stages
package pipe_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_CTRL_W = 8;
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;
endpackage

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: two-entry skid-buffered pipeline register with registered in_ready and flush
//   clk, rst            clock, synchronous active-high reset
//   flush               squash all held entries and the entry offered this cycle
//   in_valid/in_ready   upstream handshake; in_data/in_ctrl upstream payload
//   out_valid/out_ready downstream handshake; out_data/out_ctrl presented payload
//   occupancy           held entries, 0..2
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);
  localparam int W = DATA_W + CTRL_W;
  state_t st, st_nx;
  logic [W-1:0] main_q, skid_q;
  logic accept, pop, load_in, load_skid, skid_to_main;
  assign accept       = in_valid & in_ready;
  assign pop          = out_valid & out_ready;
  assign load_in      = accept & ((st == ST_EMPTY) | ((st == ST_ONE) & pop));
  assign load_skid    = accept & (st == ST_ONE) & ~pop;
  assign skid_to_main = pop & (st == ST_FULL);
  always_comb begin
    st_nx = st;
    if (st == ST_EMPTY)
      st_nx = accept ? ST_ONE : ST_EMPTY;
    else if (st == ST_ONE)
      st_nx = (accept & ~pop) ? ST_FULL : (~accept & pop) ? ST_EMPTY : ST_ONE;
    else
      st_nx = pop ? ST_ONE : ST_FULL;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= ST_EMPTY;
      main_q   <= '0;
      skid_q   <= '0;
      in_ready <= 1'b1;
    end else if (flush) begin
      st                  <= ST_EMPTY;
      main_q[W-1:DATA_W]  <= '0;
      skid_q[W-1:DATA_W]  <= '0;
      in_ready            <= 1'b1;
    end else begin
      st       <= st_nx;
      in_ready <= st_nx != ST_FULL;
      if (load_in)
        main_q <= {in_ctrl, in_data};
      else if (skid_to_main)
        main_q <= skid_q;
      if (load_skid)
        skid_q <= {in_ctrl, in_data};
    end
  end
  assign out_valid = st != ST_EMPTY;
  assign out_data  = main_q[DATA_W-1:0];
  // held ctrl may be stale after a pop to EMPTY; gate it so a bubble never carries write enables
  assign out_ctrl  = out_valid ? main_q[W-1:DATA_W] : '0;
  assign occupancy = st;
endmodule
